// File: rtl/sram_fetch_pkg.sv
// Shared types and helpers for the SRAM fetch controller: FSM state encoding
// and the lane-reversal function used on read data, write data and byte enables.
package sram_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    TURN
  } state_t;

  // Widest vector byte_swap handles; callers size-cast in and out.
  localparam int unsigned SWAP_MAX_W = 1024;
  localparam int unsigned SWAP_IDX_W = $clog2(SWAP_MAX_W);

  // Reverse `lanes` lanes of `lane_w` bits each: lane i lands in lane lanes-1-i.
  // lane_w=8 swaps bytes of a data word, lane_w=1 swaps a byte-enable vector.
  function automatic logic [SWAP_MAX_W-1:0] byte_swap(
    input logic [SWAP_MAX_W-1:0] d,
    input int unsigned           lanes,
    input int unsigned           lane_w
  );
    logic [SWAP_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < lanes; i++) begin
      for (int unsigned b = 0; b < lane_w; b++) begin
        r[SWAP_IDX_W'(i * lane_w + b)] = d[SWAP_IDX_W'((lanes - 1 - i) * lane_w + b)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_tristate.sv
// SRAM data-bus driver: the only place the inout is driven. Holds the write
// data register and the registered output enable; releases the bus on reset.
module sram_tristate #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drive_d,
  output logic [DATA_W-1:0] rd_data,
  inout  wire  [DATA_W-1:0] bus
);

  logic              drive_q;
  logic [DATA_W-1:0] dout_q;

  // NOTE: sequential state uses non-blocking assignments only, with the reset
  // in the sensitivity list so it takes effect without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drive_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      drive_q <= drive_d;
      if (load) dout_q <= load_data;
    end
  end

  // Gating with rst releases the bus in the same cycle reset is raised.
  assign bus     = (drive_q && !rst) ? dout_q : {DATA_W{1'bz}};
  assign rd_data = bus;

endmodule

// File: rtl/sram_fetch_ctrl.sv
// Registered fetch controller for the asynchronous base SRAM: one request per
// handshake, fixed wait-state access, optional byte-lane swap on both paths.
module sram_fetch_ctrl
  import sram_fetch_pkg::*;
#(
  parameter  int ADDR_W      = 20,
  parameter  int DATA_W      = 32,
  parameter  int WAIT_CYCLES = 2,
  parameter  int SWAP_BYTES  = 1,
  localparam int BE_W        = DATA_W / 8,
  localparam int OFF_W       = $clog2(BE_W),
  localparam int CNT_W       = ($clog2(WAIT_CYCLES + 1) > 1) ? $clog2(WAIT_CYCLES + 1) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [ADDR_W+OFF_W-1:0] addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic [BE_W-1:0]         be,
  output logic                    ready,
  output logic                    done,
  output logic [DATA_W-1:0]       rdata,
  inout  wire  [DATA_W-1:0]       sram_data,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [BE_W-1:0]         sram_be_n,
  output logic                    sram_ce_n,
  output logic                    sram_oe_n,
  output logic                    sram_we_n
);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BE_W-1:0]   be_n_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept, last, drive_d;
  logic [DATA_W-1:0] wdata_sw, bus_rd, rd_sw;
  logic [BE_W-1:0]   be_sw;

  generate
    if (SWAP_BYTES != 0) begin : g_swap
      assign wdata_sw = DATA_W'(byte_swap(SWAP_MAX_W'(wdata), BE_W, 8));
      assign rd_sw    = DATA_W'(byte_swap(SWAP_MAX_W'(bus_rd), BE_W, 8));
      assign be_sw    = BE_W'(byte_swap(SWAP_MAX_W'(be), BE_W, 1));
    end else begin : g_pass
      assign wdata_sw = wdata;
      assign rd_sw    = bus_rd;
      assign be_sw    = be;
    end

    if (OFF_W > 0) begin : g_lsb
      // Byte offset within a word is meaningless to a word-addressed SRAM.
      logic unused_addr_lsb;
      assign unused_addr_lsb = ^addr[OFF_W-1:0];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last      = 1'b0;
    drive_d   = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    sram_ce_n = 1'b1;
    sram_oe_n = 1'b1;
    sram_we_n = 1'b1;
    sram_be_n = '1;
    case (state_q)
      IDLE: begin
        ready = !rst;
        if (req) begin
          accept  = 1'b1;
          drive_d = we;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        drive_d   = we_q;
        sram_ce_n = rst;
        sram_oe_n = we_q || rst;
        sram_we_n = !we_q || rst;
        sram_be_n = rst ? '1 : (we_q ? be_n_q : '0);
        if (cnt_q == '0) begin
          last    = 1'b1;
          state_d = TURN;
        end
      end
      TURN: begin
        done    = !rst;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_n_q  <= '1;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        cnt_q  <= CNT_W'(WAIT_CYCLES);
        we_q   <= we;
        addr_q <= addr[ADDR_W+OFF_W-1:OFF_W];
        be_n_q <= ~be_sw;
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // Sample the bus at the edge closing the last ACCESS cycle.
      if (last && !we_q) rdata_q <= rd_sw;
    end
  end

  sram_tristate #(
    .DATA_W(DATA_W)
  ) u_tristate (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_data(wdata_sw),
    .drive_d  (drive_d),
    .rd_data  (bus_rd),
    .bus      (sram_data)
  );

  assign sram_addr = addr_q;
  assign rdata     = rdata_q;

endmodule
